// File: rtl/hamming_frame_seq.sv
// hamming_frame_seq: per-frame strobe sequencer for the serial 11/15 Hamming encode/channel/decode path.
module hamming_frame_seq #(
  parameter int DATA_W       = 11,
  parameter int CODE_W       = 15,
  parameter bit AUTO_RESTART = 1'b0
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       start,
  input  logic       abort,
  input  logic       shift,
  input  logic       dec_err,
  output logic       in_shift,
  output logic       enc_load,
  output logic       ch_shift,
  output logic       dec_load,
  output logic       out_shift,
  output logic       busy,
  output logic       done,
  output logic       err_seen,
  output logic [3:0] bit_cnt,
  output logic [7:0] frame_cnt
);
  typedef enum logic [2:0] {IDLE, COLLECT, ENCODE, TRANSMIT, DECODE, DRAIN, DONE} state_t;
  state_t     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic       err_seen_q, err_seen_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       shifting, adv, last;
  logic [3:0] len_m1;
  always_ff @(posedge clk or negedge RST)
    if (!RST) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      err_seen_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      err_seen_q  <= err_seen_d;
      frame_cnt_q <= frame_cnt_d;
    end
  always_comb begin
    shifting    = state_q == COLLECT || state_q == TRANSMIT || state_q == DRAIN;
    len_m1      = state_q == TRANSMIT ? 4'(CODE_W - 1) : 4'(DATA_W - 1);
    adv         = shifting && shift;
    last        = adv && bit_cnt_q == len_m1;
    state_d     = state_q;
    bit_cnt_d   = adv ? (last ? 4'd0 : bit_cnt_q + 4'd1) : bit_cnt_q;
    err_seen_d  = err_seen_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      IDLE: begin
        state_d   = start ? COLLECT : IDLE;
        bit_cnt_d = '0;
      end
      COLLECT:  state_d = last ? ENCODE : COLLECT;
      ENCODE:   state_d = TRANSMIT;
      TRANSMIT: state_d = last ? DECODE : TRANSMIT;
      DECODE:   state_d = DRAIN;
      DRAIN:    state_d = last ? DONE : DRAIN;
      DONE: begin
        state_d     = (AUTO_RESTART && start) ? COLLECT : IDLE;
        bit_cnt_d   = '0;
        err_seen_d  = dec_err;
        frame_cnt_d = frame_cnt_q + 8'd1;
      end
      default:  state_d = IDLE;
    endcase
    // abort wins over everything but leaves the frame statistics untouched
    if (abort) begin
      state_d     = IDLE;
      bit_cnt_d   = '0;
      err_seen_d  = err_seen_q;
      frame_cnt_d = frame_cnt_q;
    end
  end
  assign in_shift  = state_q == COLLECT && shift;
  assign enc_load  = state_q == ENCODE;
  assign ch_shift  = state_q == TRANSMIT && shift;
  assign dec_load  = state_q == DECODE;
  assign out_shift = state_q == DRAIN && shift;
  assign busy      = state_q != IDLE;
  assign done      = state_q == DONE;
  assign err_seen  = err_seen_q;
  assign bit_cnt   = bit_cnt_q;
  assign frame_cnt = frame_cnt_q;
endmodule
